pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
- Parametrised program-counter unit for the BitCruncher control path. It supersedes the fixed 8-bit increment/jump PC.
- Adds a stall, PC-relative branch, and call/return through an internal return-address stack (RAS) with full/empty/error status.
- Driven by control-unit micro-signals; the target/offset is taken from the MBR low bits.

Parameters:
- ADDR_W, 8, PC width in bits; all PC arithmetic is modulo 2^ADDR_W.
- DATA_W, 16, MBR width; must be >= ADDR_W.
- RAS_DEPTH, 4, number of return-address stack entries; >= 2, power of two not required.
- RESET_VEC, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  freeze PC and RAS; overrides all other controls.
- inc  in  1  PC <= PC+1 (C6 equivalent).
- jump  in  1  PC <= mbr_in[ADDR_W-1:0] (C14 equivalent).
- branch  in  1  PC <= PC + sext(mbr_in[ADDR_W-1:0]).
- call  in  1  push PC+1, then PC <= mbr_in[ADDR_W-1:0].
- ret  in  1  PC <= popped address.
- err_clr  in  1  clears ras_err.
- mbr_in  in  DATA_W  target address / signed offset source.
- pc_out  out  ADDR_W  current PC, registered.
- ras_full  out  1  RAS holds RAS_DEPTH entries.
- ras_empty  out  1  RAS holds 0 entries.
- ras_err  out  1  sticky overflow/underflow flag.

Behaviour:
- Reset (async, rst_n=0):
  - pc_out=RESET_VEC, RAS count=0, ras_empty=1, ras_full=0, ras_err=0.
  - RAS contents are don't-care.
  - Asserting reset mid-operation discards any pending update immediately.
- All updates happen on the rising clk edge; pc_out changes one cycle after the control is sampled. There is no combinational path from inputs to outputs.
- Priority, highest first: stall > ret > call > jump > branch > inc > hold. Only the highest asserted control acts.
- stall=1: pc_out, RAS and ras_err hold. err_clr is still honoured.
- ret:
  - If count>0: PC <= top entry, count-1.
  - If count==0 (underflow): PC holds, count stays 0, ras_err<=1.
- call:
  - If count<RAS_DEPTH: write PC+1 (mod 2^ADDR_W) to top, count+1, PC <= target.
  - If count==RAS_DEPTH (overflow): PC <= target, push discarded, contents and count unchanged, ras_err<=1.
- jump: PC <= mbr_in[ADDR_W-1:0]. mbr_in bits above ADDR_W are ignored.
- branch: offset = mbr_in[ADDR_W-1:0] read as two's complement. PC <= PC + offset, wrapping modulo 2^ADDR_W (e.g. ADDR_W=8: PC 0x02 + 0xFC = 0xFE).
- inc: PC <= PC+1; 2^ADDR_W-1 wraps to 0.
- No control asserted: PC holds.
- RAS is a LIFO indexed by count. ras_full = (count==RAS_DEPTH) and ras_empty = (count==0), both decoded from registered count.
- ras_err is sticky.
  - err_clr=1 clears it on the next edge.
  - If err_clr and a new error occur in the same cycle, set wins (ras_err=1).
- Simultaneous call+ret: ret wins; call is ignored and no push occurs.

Optional Feature:
- Macro PC_UNIT_HIST_EN.
- Defined:
  - Adds output last_pc  out  ADDR_W, reset to RESET_VEC.
  - On any non-stalled jump, branch, call, or ret that is actually taken (including overflowing call), last_pc <= pc_out value before the transfer.
  - Underflowing ret does not update last_pc.
  - inc and hold do not update last_pc.
- Undefined: the last_pc port and register are absent; all other behaviour is identical.

Test Plan:
- Reset/inc (RESET_VEC=0): release rst_n, inc=1 for 3 cycles -> pc_out 0x00,0x01,0x02,0x03. Hold at PC=0xFF with inc -> wraps to 0x00.
- Jump/branch priority: PC=0x10, jump=1, branch=1, inc=1, mbr_in=0xAB40 -> pc_out=0x40. Then branch=1, mbr_in=0x00FC -> 0x3C. Then branch, mbr_in=0x0005 -> 0x41.
- Call/ret nesting (RAS_DEPTH=4): PC=0x20, call to 0x50 -> PC=0x50, ras_empty=0. Call to 0x60 -> PC=0x60. Ret -> 0x51. Ret -> 0x21, ras_empty=1, ras_err=0.
- Overflow/underflow: 5 consecutive calls -> ras_full=1 after the 4th; 5th jumps to its target, ras_err=1, count stays 4. Then err_clr -> ras_err=0. Then 5 rets -> 4 pops, 5th holds PC with ras_err=1.
- Stall and simultaneity: stall=1 with call=1 -> pc_out and count unchanged. call+ret together with count=1 -> pop only, count=0. err_clr in the same cycle as underflow -> ras_err=1.
- Async reset mid-call: assert rst_n=0 between edges with count=3 -> pc_out=RESET_VEC, ras_empty=1 immediately, before the next clk edge. With PC_UNIT_HIST_EN: jump from 0x33 to 0x80 -> last_pc=0x33.

Source files
------------

// File: rtl/pc_unit.sv
// Program-counter unit with stall, PC-relative branch and call/return via an internal return-address stack.
// Optional PC_UNIT_HIST_EN adds a last_pc output recording the PC before each taken control transfer.
module pc_unit #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 16,
    parameter int RAS_DEPTH = 4,
    parameter int RESET_VEC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              inc,
    input  logic              jump,
    input  logic              branch,
    input  logic              call,
    input  logic              ret,
    input  logic              err_clr,
    input  logic [DATA_W-1:0] mbr_in,
    output logic [ADDR_W-1:0] pc_out,
    output logic              ras_full,
    output logic              ras_empty,
    output logic              ras_err
`ifdef PC_UNIT_HIST_EN
    ,
    output logic [ADDR_W-1:0] last_pc
`endif
);

    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(RAS_DEPTH);
    localparam logic [ADDR_W-1:0] RST_PC  = ADDR_W'(RESET_VEC);

    logic [ADDR_W-1:0] pc_q, pc_nxt, pc_plus1, target;
    logic [CNT_W-1:0]  cnt_q, cnt_nxt, cnt_dec;
    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
    logic              push, err_set, xfer;

    assign target   = mbr_in[ADDR_W-1:0];
    assign pc_plus1 = pc_q + ADDR_W'(1);
    assign cnt_dec  = cnt_q - CNT_W'(1);

    // Upper MBR bits carry no meaning for the PC.
    generate
        if (DATA_W > ADDR_W) begin : g_hi
            logic unused_mbr_hi;
            assign unused_mbr_hi = ^mbr_in[DATA_W-1:ADDR_W];
        end
    endgenerate

    always_comb begin
        pc_nxt  = pc_q;
        cnt_nxt = cnt_q;
        push    = 1'b0;
        err_set = 1'b0;
        xfer    = 1'b0;
        if (!stall) begin
            if (ret) begin
                if (cnt_q != '0) begin
                    pc_nxt  = ras_mem[cnt_dec];
                    cnt_nxt = cnt_dec;
                    xfer    = 1'b1;
                end else begin
                    err_set = 1'b1;
                end
            end else if (call) begin
                // An overflowing call still transfers; only the push is lost.
                pc_nxt = target;
                xfer   = 1'b1;
                if (cnt_q != DEPTH_C) begin
                    push    = 1'b1;
                    cnt_nxt = cnt_q + CNT_W'(1);
                end else begin
                    err_set = 1'b1;
                end
            end else if (jump) begin
                pc_nxt = target;
                xfer   = 1'b1;
            end else if (branch) begin
                // Modulo add of the raw offset equals adding its sign extension.
                pc_nxt = pc_q + target;
                xfer   = 1'b1;
            end else if (inc) begin
                pc_nxt = pc_plus1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RST_PC;
            cnt_q   <= '0;
            ras_err <= 1'b0;
        end else begin
            pc_q  <= pc_nxt;
            cnt_q <= cnt_nxt;
            if (err_set)
                ras_err <= 1'b1;
            else if (err_clr)
                ras_err <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            ras_mem[cnt_q] <= pc_plus1;
    end

`ifdef PC_UNIT_HIST_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_pc <= RST_PC;
        else if (xfer)
            last_pc <= pc_q;
    end
`else
    logic unused_xfer;
    assign unused_xfer = xfer;
`endif

    assign pc_out    = pc_q;
    assign ras_full  = (cnt_q == DEPTH_C);
    assign ras_empty = (cnt_q == '0);

endmodule

// File: tb/tb_pc_unit.sv
// Directed table-driven bench for pc_unit (ADDR_W=8, RAS_DEPTH=4, RESET_VEC=0).
// Checks last_pc as well when PC_UNIT_HIST_EN is defined.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 0, inc = 0, jump = 0, branch = 0, call = 0, ret = 0, err_clr = 0;
    logic [15:0] mbr_in = '0;
    logic [7:0]  pc_out;
    logic        ras_full, ras_empty, ras_err;
`ifdef PC_UNIT_HIST_EN
    logic [7:0]  last_pc;
`endif

    pc_unit #(.ADDR_W(8), .DATA_W(16), .RAS_DEPTH(4), .RESET_VEC(0)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .inc(inc), .jump(jump),
        .branch(branch), .call(call), .ret(ret), .err_clr(err_clr),
        .mbr_in(mbr_in), .pc_out(pc_out), .ras_full(ras_full),
        .ras_empty(ras_empty), .ras_err(ras_err)
`ifdef PC_UNIT_HIST_EN
        , .last_pc(last_pc)
`endif
    );

    // clock / reset
    always #5 clk = ~clk;

    // control bit positions: {stall, ret, call, jump, branch, inc, err_clr}
    localparam logic [6:0] C_S = 7'b1000000, C_R = 7'b0100000, C_C = 7'b0010000,
                           C_J = 7'b0001000, C_B = 7'b0000100, C_I = 7'b0000010,
                           C_E = 7'b0000001, C_N = 7'b0000000;

    typedef struct {
        logic [6:0]  ctl;
        logic [15:0] mbr;
        logic [7:0]  pc;
        logic        full;
        logic        empty;
        logic        err;
    } vec_t;

    vec_t        vecs [32];
    logic [7:0]  exp_q [$];
    int          total = 0;
    int          bad = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [6:0] ctl, input logic [15:0] mbr);
        @(negedge clk);
        {stall, ret, call, jump, branch, inc, err_clr} = ctl;
        mbr_in = mbr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        {stall, ret, call, jump, branch, inc, err_clr} = C_N;
    endtask

    initial begin
        // PC starts at 0 after reset
        vecs[0]  = '{C_I, 16'h0000, 8'h01, 0, 1, 0};
        vecs[1]  = '{C_I, 16'h0000, 8'h02, 0, 1, 0};
        vecs[2]  = '{C_I, 16'h0000, 8'h03, 0, 1, 0};
        vecs[3]  = '{C_J, 16'h00FF, 8'hFF, 0, 1, 0};
        vecs[4]  = '{C_I, 16'h0000, 8'h00, 0, 1, 0};
        vecs[5]  = '{C_J, 16'h0010, 8'h10, 0, 1, 0};
        vecs[6]  = '{C_J | C_B | C_I, 16'hAB40, 8'h40, 0, 1, 0};
        vecs[7]  = '{C_B, 16'h00FC, 8'h3C, 0, 1, 0};
        vecs[8]  = '{C_B, 16'h0005, 8'h41, 0, 1, 0};
        vecs[9]  = '{C_J, 16'h0020, 8'h20, 0, 1, 0};
        vecs[10] = '{C_C, 16'h0050, 8'h50, 0, 0, 0};
        vecs[11] = '{C_C, 16'h0060, 8'h60, 0, 0, 0};
        vecs[12] = '{C_R, 16'h0000, 8'h51, 0, 0, 0};
        vecs[13] = '{C_R, 16'h0000, 8'h21, 0, 1, 0};
        // fill the stack: pushes 0x22, 0x71, 0x72, 0x73
        vecs[14] = '{C_C, 16'h0070, 8'h70, 0, 0, 0};
        vecs[15] = '{C_C, 16'h0071, 8'h71, 0, 0, 0};
        vecs[16] = '{C_C, 16'h0072, 8'h72, 0, 0, 0};
        vecs[17] = '{C_C, 16'h0073, 8'h73, 1, 0, 0};
        vecs[18] = '{C_C, 16'h0074, 8'h74, 1, 0, 1};
        vecs[19] = '{C_E, 16'h0000, 8'h74, 1, 0, 0};
        vecs[20] = '{C_R, 16'h0000, 8'h73, 0, 0, 0};
        vecs[21] = '{C_R, 16'h0000, 8'h72, 0, 0, 0};
        vecs[22] = '{C_R, 16'h0000, 8'h71, 0, 0, 0};
        vecs[23] = '{C_R, 16'h0000, 8'h22, 0, 1, 0};
        vecs[24] = '{C_R, 16'h0000, 8'h22, 0, 1, 1};
        vecs[25] = '{C_E, 16'h0000, 8'h22, 0, 1, 0};
        vecs[26] = '{C_S | C_C, 16'h0099, 8'h22, 0, 1, 0};
        vecs[27] = '{C_C, 16'h0030, 8'h30, 0, 0, 0};
        vecs[28] = '{C_C | C_R, 16'h0090, 8'h23, 0, 1, 0};
        vecs[29] = '{C_R | C_E, 16'h0000, 8'h23, 0, 1, 1};
        vecs[30] = '{C_S | C_E, 16'h0000, 8'h23, 0, 1, 0};
        vecs[31] = '{C_S | C_I | C_J, 16'h0055, 8'h23, 0, 1, 0};

        // reset state
        #2;
        check("rst_pc", pc_out, 8'h00);
        check("rst_empty", {7'd0, ras_empty}, 8'd1);
        check("rst_full", {7'd0, ras_full}, 8'd0);
        check("rst_err", {7'd0, ras_err}, 8'd0);
`ifdef PC_UNIT_HIST_EN
        check("rst_last_pc", last_pc, 8'h00);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        drive(C_N, 16'h0000);
        check("hold_pc", pc_out, 8'h00);

        for (int i = 0; i < 32; i++) begin
            exp_q.push_back(vecs[i].pc);
            drive(vecs[i].ctl, vecs[i].mbr);
            check($sformatf("v%0d_pc", i), pc_out, exp_q.pop_front());
            check($sformatf("v%0d_full", i), {7'd0, ras_full}, {7'd0, vecs[i].full});
            check($sformatf("v%0d_empty", i), {7'd0, ras_empty}, {7'd0, vecs[i].empty});
            check($sformatf("v%0d_err", i), {7'd0, ras_err}, {7'd0, vecs[i].err});
        end

        // async reset with three entries on the stack
        drive(C_C, 16'h0040);
        drive(C_C, 16'h0041);
        drive(C_C, 16'h0042);
        check("pre_rst_pc", pc_out, 8'h42);
        check("pre_rst_empty", {7'd0, ras_empty}, 8'd0);
        @(negedge clk);
        idle();
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_pc", pc_out, 8'h00);
        check("async_rst_empty", {7'd0, ras_empty}, 8'd1);
        @(negedge clk);
        rst_n = 1'b1;
        drive(C_R, 16'h0000);
        check("post_rst_underflow_pc", pc_out, 8'h00);
        check("post_rst_underflow_err", {7'd0, ras_err}, 8'd1);
        drive(C_E, 16'h0000);

`ifdef PC_UNIT_HIST_EN
        drive(C_J, 16'h0033);
        drive(C_J, 16'h0080);
        check("hist_jump", last_pc, 8'h33);
        drive(C_I, 16'h0000);
        check("hist_inc_hold", last_pc, 8'h33);
        drive(C_R, 16'h0000);
        check("hist_underflow_hold", last_pc, 8'h33);
        drive(C_C, 16'h0010);
        check("hist_call", last_pc, 8'h81);
        drive(C_R, 16'h0000);
        check("hist_ret", last_pc, 8'h10);
        check("hist_ret_pc", pc_out, 8'h82);
`endif

        idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
